pe_single_module: RTL and testbench
===================================

Name: pe_single_module

Overview:
- Single processing element that computes a 2x2 "valid" 2-D convolution (cross-correlation, no kernel flip) of a 4x4 unsigned 8-bit matrix A with a 3x3 unsigned 8-bit kernel B.
- Uses one multiplier-accumulator: 9 MAC cycles per output, 4 outputs.
- Serves as the single-PE reference mode alongside the systolic-array mode; results stream out one per en_result pulse.

Parameters:
- DATA_W, 8, width of every A/B element and of acc_out.
- ACC_W, 20, internal accumulator width (holds the max 9*255*255 = 585225 without overflow).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en_single  input  1  start pulse, sampled on rising clk while IDLE.
- a_R_C (R,C = 1..4; 16 ports)  input  DATA_W  A[R][C], unsigned.
- b_R_C (R,C = 1..3; 9 ports)  input  DATA_W  B[R][C], unsigned.
- en_result  output  1  one-cycle strobe: acc_out holds a new result.
- acc_out  output  DATA_W  current convolution result.
- pe_done  output  1  one-cycle strobe with the 4th (last) result.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state = IDLE; accumulator, indices, operand latches and acc_out all cleared to 0.
  - en_result = 0, pe_done = 0.
  - The operation in progress is aborted.
- IDLE:
  - On the edge where en_single = 1 (call it E0): latch all 25 operands into internal registers, clear the accumulator and indices, go to BUSY.
  - Inputs may change freely after E0.
- BUSY:
  - Output index k = 0..3 maps to (r,c) = (0,0), (0,1), (1,0), (1,1), in that order.
  - Kernel index t = 0..8 maps to (i,j) in row-major order.
  - Each cycle adds the 16-bit unsigned product a[r+i][c+j]*b[i][j] to the ACC_W-bit accumulator.
  - On the edge that adds term t = 8:
    - acc_out <= the ACC_W-bit sum (acc + product) reduced to DATA_W bits (see Optional Feature).
    - en_result <= 1 for exactly one cycle.
    - The accumulator restarts at 0 for the next k.
  - Result k is registered at edge E(9+9k): E9, E18, E27, E36. en_result is high in the cycle following each of those edges; exactly 4 pulses per operation.
  - pe_done <= 1 at E36, in the same cycle as the 4th en_result; then return to IDLE.
  - Total latency from start edge to the final result: 36 clocks.
- acc_out holds its last value between pulses and after done, until reset or the next result.
- en_single asserted while BUSY is ignored; there is no restart.
- en_single held high continuously re-triggers only from IDLE, i.e. on the edge after E36.
- All arithmetic is unsigned; no intermediate overflow is possible with ACC_W = 20.

Optional Feature:
- Macro: PE_SINGLE_SAT_EN.
- Defined: acc_out = 255 when the 20-bit sum exceeds 255; otherwise the sum.
- Undefined (default): acc_out = sum[7:0] (modulo-256 truncation).
- Timing and handshakes are identical in both builds.

Test Plan:
- Reference vectors:
  - A = {233,123,12,3 / 5,2,3,3 / 9,255,1,12 / 13,64,55,27}, B = {13,2,3 / 2,1,50 / 51,52,1}.
  - Full sums are 17193, 14858, 4447, 7303.
  - Default build: reset pulse, then en_single for one cycle -> en_result pulses 9, 18, 27 and 36 clocks after the start edge with acc_out = 41, 10, 95, 135; pe_done is high only with the 4th pulse.
- Same vectors with PE_SINGLE_SAT_EN -> acc_out = 255, 255, 255, 255.
- Small values:
  - A = all 1, B = all 1 -> four results of 9 (no truncation).
  - A[r][c] = 4r+c (0..15), B = identity centre only (b_2_2 = 1, rest 0) -> results 5, 6, 9, 10.
- Start while BUSY: pulse en_single again at clock 5 after the start edge, and change a_1_1 to 0 -> results unchanged (operands latched); still exactly 4 en_result pulses and one pe_done.
- Mid-operation reset: assert reset at clock 12 -> en_result, pe_done and acc_out go to 0 immediately (asynchronously). A new en_single after release runs a full 36-cycle operation with correct results.
- Back-to-back runs: en_single held high -> second operation starts on the edge after pe_done and reproduces the same 4 results.

Source files
------------

// File: rtl/pe_single_module.sv
// Single-PE 2x2 valid cross-correlation of a 4x4 matrix with a 3x3 kernel, one MAC per clock.
// Optional build macro PE_SINGLE_SAT_EN: saturate each result to 255 instead of modulo-256 truncation.
module pe_single_module #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_single,
  input  logic [DATA_W-1:0] a_1_1, input logic [DATA_W-1:0] a_1_2,
  input  logic [DATA_W-1:0] a_1_3, input logic [DATA_W-1:0] a_1_4,
  input  logic [DATA_W-1:0] a_2_1, input logic [DATA_W-1:0] a_2_2,
  input  logic [DATA_W-1:0] a_2_3, input logic [DATA_W-1:0] a_2_4,
  input  logic [DATA_W-1:0] a_3_1, input logic [DATA_W-1:0] a_3_2,
  input  logic [DATA_W-1:0] a_3_3, input logic [DATA_W-1:0] a_3_4,
  input  logic [DATA_W-1:0] a_4_1, input logic [DATA_W-1:0] a_4_2,
  input  logic [DATA_W-1:0] a_4_3, input logic [DATA_W-1:0] a_4_4,
  input  logic [DATA_W-1:0] b_1_1, input logic [DATA_W-1:0] b_1_2,
  input  logic [DATA_W-1:0] b_1_3,
  input  logic [DATA_W-1:0] b_2_1, input logic [DATA_W-1:0] b_2_2,
  input  logic [DATA_W-1:0] b_2_3,
  input  logic [DATA_W-1:0] b_3_1, input logic [DATA_W-1:0] b_3_2,
  input  logic [DATA_W-1:0] b_3_3,
  output logic              en_result,
  output logic [DATA_W-1:0] acc_out,
  output logic              pe_done
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_a [16];
  logic [DATA_W-1:0] r_b [9];
  logic [DATA_W-1:0] w_a [16];
  logic [DATA_W-1:0] w_b [9];
  logic [ACC_W-1:0]  r_acc;
  logic [1:0]        r_k;
  logic [3:0]        r_t;
  logic [DATA_W-1:0] r_acc_out;
  logic              r_en_result;
  logic              r_done;

  logic [1:0]          w_i, w_j;
  logic [1:0]          w_row, w_col;
  logic [DATA_W-1:0]   w_a_op, w_b_op;
  logic [2*DATA_W-1:0] w_prod;
  logic [ACC_W-1:0]    w_sum;
  logic                w_last_t, w_last_k;

  function automatic logic [DATA_W-1:0] reduce_sum(input logic [ACC_W-1:0] s);
`ifdef PE_SINGLE_SAT_EN
    if (|s[ACC_W-1:DATA_W]) reduce_sum = '1;
    else                    reduce_sum = s[DATA_W-1:0];
`else
    reduce_sum = s[DATA_W-1:0];
`endif
  endfunction

  assign w_a = '{a_1_1, a_1_2, a_1_3, a_1_4, a_2_1, a_2_2, a_2_3, a_2_4,
                 a_3_1, a_3_2, a_3_3, a_3_4, a_4_1, a_4_2, a_4_3, a_4_4};
  assign w_b = '{b_1_1, b_1_2, b_1_3, b_2_1, b_2_2, b_2_3, b_3_1, b_3_2, b_3_3};

  // Kernel tap t -> (i,j), row-major
  always_comb begin
    w_i = 2'd0;
    w_j = 2'd0;
    case (r_t)
      4'd1: begin w_i = 2'd0; w_j = 2'd1; end
      4'd2: begin w_i = 2'd0; w_j = 2'd2; end
      4'd3: begin w_i = 2'd1; w_j = 2'd0; end
      4'd4: begin w_i = 2'd1; w_j = 2'd1; end
      4'd5: begin w_i = 2'd1; w_j = 2'd2; end
      4'd6: begin w_i = 2'd2; w_j = 2'd0; end
      4'd7: begin w_i = 2'd2; w_j = 2'd1; end
      4'd8: begin w_i = 2'd2; w_j = 2'd2; end
      default: begin w_i = 2'd0; w_j = 2'd0; end
    endcase
  end

  // Output index k selects window origin (r,c) = (k[1], k[0])
  assign w_row    = {1'b0, r_k[1]} + w_i;
  assign w_col    = {1'b0, r_k[0]} + w_j;
  assign w_a_op   = r_a[{w_row, w_col}];
  assign w_b_op   = r_b[r_t];
  assign w_prod   = w_a_op * w_b_op;
  assign w_sum    = r_acc + ACC_W'(w_prod);
  assign w_last_t = (r_t == 4'd8);
  assign w_last_k = (r_k == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (en_single) w_state_nxt = BUSY;
      BUSY:    if (w_last_t && w_last_k) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_k         <= '0;
      r_t         <= '0;
      r_acc_out   <= '0;
      r_en_result <= 1'b0;
      r_done      <= 1'b0;
      for (int n = 0; n < 16; n++) r_a[n] <= '0;
      for (int n = 0; n < 9; n++)  r_b[n] <= '0;
    end else begin
      r_en_result <= 1'b0;
      r_done      <= 1'b0;
      if (r_state == IDLE) begin
        if (en_single) begin
          for (int n = 0; n < 16; n++) r_a[n] <= w_a[n];
          for (int n = 0; n < 9; n++)  r_b[n] <= w_b[n];
          r_acc <= '0;
          r_k   <= '0;
          r_t   <= '0;
        end
      end else if (w_last_t) begin
        r_acc       <= '0;
        r_acc_out   <= reduce_sum(w_sum);
        r_en_result <= 1'b1;
        r_done      <= w_last_k;
        r_t         <= '0;
        r_k         <= r_k + 2'd1;
      end else begin
        r_acc <= w_sum;
        r_t   <= r_t + 4'd1;
      end
    end
  end

  assign en_result = r_en_result;
  assign acc_out   = r_acc_out;
  assign pe_done   = r_done;

endmodule

// File: tb/tb_pe_single_module.sv
// Scoreboard bench for pe_single_module: stimulus pushes expected results, a negedge monitor checks them.
module tb_pe_single_module;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en_single = 1'b0;
  logic [7:0] a [16];
  logic [7:0] b [9];
  logic       en_result;
  logic [7:0] acc_out;
  logic       pe_done;

  int     nchk = 0;
  int     nfail = 0;
  longint cyc = 0;
  longint t0 = 0;

  typedef struct { int val; bit done; longint at; } exp_t;
  exp_t q[$];

`ifdef PE_SINGLE_SAT_EN
  localparam int R0 = 255, R1 = 255, R2 = 255, R3 = 255;
`else
  localparam int R0 = 41, R1 = 10, R2 = 95, R3 = 135;
`endif

  pe_single_module #(.DATA_W(8), .ACC_W(20)) dut (
    .clk(clk), .reset(reset), .en_single(en_single),
    .a_1_1(a[0]),  .a_1_2(a[1]),  .a_1_3(a[2]),  .a_1_4(a[3]),
    .a_2_1(a[4]),  .a_2_2(a[5]),  .a_2_3(a[6]),  .a_2_4(a[7]),
    .a_3_1(a[8]),  .a_3_2(a[9]),  .a_3_3(a[10]), .a_3_4(a[11]),
    .a_4_1(a[12]), .a_4_2(a[13]), .a_4_3(a[14]), .a_4_4(a[15]),
    .b_1_1(b[0]), .b_1_2(b[1]), .b_1_3(b[2]),
    .b_2_1(b[3]), .b_2_2(b[4]), .b_2_3(b[5]),
    .b_3_1(b[6]), .b_3_2(b[7]), .b_3_3(b[8]),
    .en_result(en_result), .acc_out(acc_out), .pe_done(pe_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every output strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && (en_result || pe_done)) begin
      if (q.size() == 0) begin
        check("unexpected_strobe", {en_result, pe_done}, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("en_result", en_result, 1);
        check("acc_out", acc_out, e.val);
        check("pe_done", pe_done, e.done);
        check("latency_cycle", cyc, e.at);
      end
    end
  end

  task automatic load_ref();
    int av [16] = '{233,123,12,3, 5,2,3,3, 9,255,1,12, 13,64,55,27};
    int bv [9]  = '{13,2,3, 2,1,50, 51,52,1};
    for (int n = 0; n < 16; n++) a[n] = 8'(av[n]);
    for (int n = 0; n < 9; n++)  b[n] = 8'(bv[n]);
  endtask

  task automatic push4(input longint base, input int v0, input int v1, input int v2, input int v3);
    int v [4];
    v = '{v0, v1, v2, v3};
    for (int k = 0; k < 4; k++) q.push_back('{v[k], k == 3, base + 9 + 9 * k});
  endtask

  // Drive en_single for the start edge E0 and record its cycle number
  task automatic start(input bit hold);
    @(negedge clk);
    en_single = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    if (!hold) en_single = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check(name, q.size(), 0);
    repeat (12) @(posedge clk);
  endtask

  initial begin
    load_ref();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_en_result", en_result, 0);
    check("reset_pe_done", pe_done, 0);
    check("reset_acc_out", acc_out, 0);

    // Reference vectors
    start(1'b0);
    push4(t0, R0, R1, R2, R3);
    wait_empty("ref_drain");

    // All ones
    for (int n = 0; n < 16; n++) a[n] = 8'd1;
    for (int n = 0; n < 9; n++)  b[n] = 8'd1;
    start(1'b0);
    push4(t0, 9, 9, 9, 9);
    wait_empty("ones_drain");

    // Ramp A with centre-only kernel
    for (int n = 0; n < 16; n++) a[n] = 8'(n);
    for (int n = 0; n < 9; n++)  b[n] = 8'd0;
    b[4] = 8'd1;
    start(1'b0);
    push4(t0, 5, 6, 9, 10);
    wait_empty("centre_drain");

    // Start pulse while busy plus operand change must have no effect
    load_ref();
    start(1'b0);
    push4(t0, R0, R1, R2, R3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    en_single = 1'b1;
    a[0] = 8'd0;
    @(negedge clk);
    en_single = 1'b0;
    wait_empty("busy_restart_drain");
    load_ref();

    // Asynchronous reset mid-operation
    start(1'b0);
    push4(t0, R0, R1, R2, R3);
    repeat (12) @(posedge clk);
    #2;
    check("pre_reset_acc_out", acc_out, R0);
    reset = 1'b1;
    #1;
    check("async_rst_en_result", en_result, 0);
    check("async_rst_pe_done", pe_done, 0);
    check("async_rst_acc_out", acc_out, 0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    check("post_reset_idle_acc", acc_out, 0);
    start(1'b0);
    push4(t0, R0, R1, R2, R3);
    wait_empty("post_reset_drain");

    // Back-to-back with en_single held high
    start(1'b1);
    push4(t0, R0, R1, R2, R3);
    push4(t0 + 37, R0, R1, R2, R3);
    while (cyc < t0 + 40) @(posedge clk);
    @(negedge clk);
    en_single = 1'b0;
    wait_empty("b2b_drain");
    repeat (40) @(posedge clk);
    check("final_queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
